// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and slot price lookup
// for the vending machine controller.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DISP, PAYOUT} state_e;

    localparam int NSLOT   = 4;
    localparam int COIN_P1 = 1;
    localparam int COIN_P5 = 5;

    function automatic int unsigned price_of(input logic [1:0] slot,
                                             input int unsigned p0, p1, p2, p3);
        return slot == 2'd0 ? p0 : slot == 2'd1 ? p1 : slot == 2'd2 ? p2 : p3;
    endfunction

endpackage

// File: rtl/vend_payout.sv
// vend_payout: credit register that tracks load_val while start is high and,
// once start drops, counts down one coin per c1 pulse (high one, low one).
module vend_payout #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         c1,
    output logic [W-1:0] cnt,
    output logic         done
);

    logic [W-1:0] cnt_d, cnt_q;
    logic         c1_d, c1_q;
    logic         fire;

    always_comb begin
        fire  = !start && cnt_q != '0 && !c1_q;
        cnt_d = start ? load_val : fire ? cnt_q - W'(1) : cnt_q;
        c1_d  = fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            c1_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            c1_q  <= c1_d;
        end
    end

    assign c1   = c1_q;
    assign cnt  = cnt_q;
    assign done = cnt_q == '0;

endmodule

// File: rtl/vend_controller.sv
// vend_controller: 4-slot vending sequencer; collects coins, validates selections,
// handshakes with the dispenser and pays change through vend_payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE0      = 3,
    parameter int unsigned PRICE1      = 5,
    parameter int unsigned PRICE2      = 7,
    parameter int unsigned PRICE3      = 9,
    parameter int          CREDIT_W    = 5,
    parameter int unsigned MAX_CREDIT  = 20,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p1,
    input  logic                p5,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic [NSLOT-1:0]    stock_empty,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_slot,
    output logic                c1,
    output logic [CREDIT_W-1:0] credit,
    output logic                deny,
    output logic                coin_rej,
    output logic                fault,
    output logic                busy
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_e              st_d, st_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                disp_req_d, disp_req_q;
    logic [1:0]          disp_slot_d, disp_slot_q;
    logic                deny_d, deny_q;
    logic                coin_rej_d, coin_rej_q;
    logic                fault_d, fault_q;
    logic                busy_d, busy_q;
    logic [TW-1:0]       tmr_d, tmr_q;

    logic [CREDIT_W:0]   coin_val, sum;
    logic [CREDIT_W-1:0] sel_price, slot_price;
    logic                coin, fits, sel_ok, pay_done;

    assign coin       = p1 | p5;
    assign coin_val   = (CREDIT_W+1)'(p1 ? COIN_P1 : 0) + (CREDIT_W+1)'(p5 ? COIN_P5 : 0);
    assign sum        = {1'b0, credit} + coin_val;
    assign fits       = sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign sel_price  = CREDIT_W'(price_of(sel, PRICE0, PRICE1, PRICE2, PRICE3));
    assign slot_price = CREDIT_W'(price_of(disp_slot_q, PRICE0, PRICE1, PRICE2, PRICE3));
    // Price check deliberately uses the pre-coin credit.
    assign sel_ok     = !fault_q && !stock_empty[sel] && credit >= sel_price;

    always_comb begin
        st_d        = st_q;
        credit_d    = credit;
        disp_req_d  = disp_req_q;
        disp_slot_d = disp_slot_q;
        fault_d     = fault_q;
        tmr_d       = tmr_q;
        deny_d      = sel_valid;
        coin_rej_d  = coin && (st_q == DISP || st_q == PAYOUT || !fits);
        if ((st_q == IDLE || st_q == COLLECT) && coin && fits)
            credit_d = sum[CREDIT_W-1:0];
        case (st_q)
            IDLE: st_d = coin && fits ? COLLECT : IDLE;
            COLLECT: begin
                if (cancel) begin
                    st_d   = PAYOUT;
                    deny_d = 1'b0;
                end else if (sel_valid && sel_ok) begin
                    st_d        = DISP;
                    disp_req_d  = 1'b1;
                    disp_slot_d = sel;
                    tmr_d       = '0;
                    deny_d      = 1'b0;
                end
            end
            DISP: begin
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    credit_d   = credit - slot_price;
                    st_d       = credit_d != '0 ? PAYOUT : IDLE;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    disp_req_d = 1'b0;
                    fault_d    = 1'b1;
                    st_d       = PAYOUT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: st_d = pay_done ? IDLE : PAYOUT;
        endcase
        busy_d = st_d == DISP || st_d == PAYOUT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= IDLE;
            disp_req_q  <= 1'b0;
            disp_slot_q <= '0;
            deny_q      <= 1'b0;
            coin_rej_q  <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            tmr_q       <= '0;
        end else begin
            st_q        <= st_d;
            disp_req_q  <= disp_req_d;
            disp_slot_q <= disp_slot_d;
            deny_q      <= deny_d;
            coin_rej_q  <= coin_rej_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
            tmr_q       <= tmr_d;
        end
    end

    // The payout block owns the credit register: it follows credit_d outside
    // PAYOUT and counts itself down while paying.
    vend_payout #(.W(CREDIT_W)) u_payout (
        .clk      (clk),
        .reset    (reset),
        .start    (st_q != PAYOUT),
        .load_val (credit_d),
        .c1       (c1),
        .cnt      (credit),
        .done     (pay_done)
    );

    assign disp_req  = disp_req_q;
    assign disp_slot = disp_slot_q;
    assign deny      = deny_q;
    assign coin_rej  = coin_rej_q;
    assign fault     = fault_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: table, directed and randomized checks of vend_controller
// against a queue-based reference model of the vending rules.
module tb_vend_controller;

    localparam int MAXC = 20;
    localparam int TMO  = 15;

    typedef struct packed {
        logic       p1;
        logic       p5;
        logic       sv;
        logic [1:0] sel;
        logic       cancel;
        logic [3:0] se;
        logic       ack;
    } in_t;

    typedef struct {
        in_t         i;
        logic [12:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p1 = 1'b0, p5 = 1'b0, sel_valid = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] stock_empty = 4'd0;
    logic       disp_req, c1, deny, coin_rej, fault, busy;
    logic [1:0] disp_slot;
    logic [4:0] credit;
    logic [12:0] act;

    int n_vec = 0;
    int n_bad = 0;
    int prices [4] = '{3, 5, 7, 9};

    int   m_credit, m_age;
    logic [1:0] m_slot;
    bit   m_fault, m_disp, e_c1, e_deny, e_rej;
    bit   pay_q [$];

    vend_controller dut (
        .clk        (clk),
        .reset      (reset),
        .p1         (p1),
        .p5         (p5),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .stock_empty(stock_empty),
        .disp_ack   (disp_ack),
        .disp_req   (disp_req),
        .disp_slot  (disp_slot),
        .c1         (c1),
        .credit     (credit),
        .deny       (deny),
        .coin_rej   (coin_rej),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign act = {disp_req, disp_slot, c1, credit, deny, coin_rej, fault, busy};

    function automatic in_t mk(input int a, b, c, s, cn, ak, se);
        return {1'(a), 1'(b), 1'(c), 2'(s), 1'(cn), 4'(se), 1'(ak)};
    endfunction

    function automatic logic [12:0] ex(input int rq, sl, cc, cr, dn, rj, ft, bz);
        return {1'(rq), 2'(sl), 1'(cc), 5'(cr), 1'(dn), 1'(rj), 1'(ft), 1'(bz)};
    endfunction

    function automatic void model_clear();
        m_credit = 0; m_age = 0; m_slot = 2'd0; m_fault = 0; m_disp = 0;
        e_c1 = 0; e_deny = 0; e_rej = 0;
        pay_q.delete();
    endfunction

    // Change is a queue of future c1 values: each owed peso is one high then one low cycle.
    function automatic void refund(input int n);
        for (int k = 0; k < n; k++) begin
            pay_q.push_back(1'b1);
            pay_q.push_back(1'b0);
        end
    endfunction

    function automatic void model_step(input in_t in);
        int  v, old;
        bit  paying, collecting;
        v = int'(in.p1) + 5 * int'(in.p5);
        old = m_credit;
        paying = pay_q.size() != 0;
        collecting = !paying && !m_disp && m_credit > 0;
        e_c1 = 0; e_deny = 0; e_rej = 0;
        if (paying) begin
            e_c1 = pay_q.pop_front();
            m_credit -= int'(e_c1);
            e_rej = v != 0;
            e_deny = in.sv;
        end else if (m_disp) begin
            e_rej = v != 0;
            e_deny = in.sv;
            if (in.ack) begin
                m_credit -= prices[m_slot];
                m_disp = 0;
                refund(m_credit);
            end else if (m_age == TMO - 1) begin
                m_disp = 0;
                m_fault = 1;
                refund(m_credit);
            end else begin
                m_age++;
            end
        end else begin
            if (v != 0) begin
                if (old + v <= MAXC) m_credit = old + v;
                else e_rej = 1;
            end
            if (collecting && in.cancel) refund(m_credit);
            else if (in.sv) begin
                if (collecting && !m_fault && !in.se[in.sel] && old >= prices[in.sel]) begin
                    m_disp = 1; m_age = 0; m_slot = in.sel;
                end else begin
                    e_deny = 1;
                end
            end
        end
    endfunction

    function automatic logic [12:0] model_out();
        return {m_disp, m_slot, e_c1, 5'(m_credit), e_deny, e_rej, m_fault, m_disp || pay_q.size() != 0};
    endfunction

    task automatic check(input string name, input logic [12:0] a, input logic [12:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got req/slot/c1/credit/deny/rej/fault/busy=%b, expected %b", name, a, e);
        end
    endtask

    task automatic step(input in_t in, input string name);
        {p1, p5, sel_valid, sel, cancel, stock_empty, disp_ack} = in;
        @(posedge clk);
        model_step(in);
        #1;
        check(name, act, model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        {p1, p5, sel_valid, sel, cancel, stock_empty, disp_ack} = '0;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, output int pulses);
        pulses = 0;
        for (int k = 0; k < 80 && busy; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0), name);
            pulses += int'(c1);
        end
        check({name, "_end"}, {12'b0, busy}, 13'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [$];
        in_t  idle, rin;
        int   pulses;
        logic [3:0] rse;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        // p5, p1, select slot 1, ack on the third DISP cycle, one change coin.
        tbl.push_back('{mk(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 5, 0, 0, 0, 0)});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 6, 0, 0, 0, 0)});
        tbl.push_back('{mk(0, 0, 1, 1, 0, 0, 0), ex(1, 1, 0, 6, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(1, 1, 0, 6, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(1, 1, 0, 6, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0), ex(0, 1, 0, 1, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0, 0)});
        // credit 3, slot 3 too expensive, then cancel pays 3 coins.
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 2, 0, 0, 0, 0)});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 3, 0, 0, 0, 0)});
        tbl.push_back('{mk(0, 0, 1, 3, 0, 0, 0), ex(0, 1, 0, 3, 1, 0, 0, 0)});
        tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 0), ex(0, 1, 0, 3, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 2, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 2, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 1, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 1, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0, 0)});
        // fill to 18, reject overflowing p5 and p1+p5, accept p1 to 19.
        for (int k = 1; k <= 3; k++) tbl.push_back('{mk(0, 1, 0, 0, 0, 0, 0), ex(0, 1, 0, 5 * k, 0, 0, 0, 0)});
        for (int k = 1; k <= 3; k++) tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 15 + k, 0, 0, 0, 0)});
        tbl.push_back('{mk(0, 1, 0, 0, 0, 0, 0), ex(0, 1, 0, 18, 0, 1, 0, 0)});
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 19, 0, 0, 0, 0)});
        tbl.push_back('{mk(1, 1, 0, 0, 0, 0, 0), ex(0, 1, 0, 19, 0, 1, 0, 0)});

        do_reset();
        check("reset_state", act, 13'b0);
        foreach (tbl[k]) begin
            step(tbl[k].i, "table_model");
            check($sformatf("table%0d", k), act, tbl[k].e);
        end
        step(mk(0, 0, 0, 0, 1, 0, 0), "cancel19");
        drain("refund19", pulses);
        check("refund19_pulses", 13'(pulses), 13'd19);

        // Dispenser never acknowledges: timeout, fault, full refund, later selections denied.
        do_reset();
        step(mk(0, 1, 0, 0, 0, 0, 0), "tmo_coin");
        step(mk(0, 0, 1, 1, 0, 0, 0), "tmo_sel");
        repeat (TMO - 1) step(idle, "tmo_wait");
        check("pre_timeout", {11'b0, disp_req, fault}, 13'b10);
        step(idle, "tmo_edge");
        check("timeout", {11'b0, disp_req, fault}, 13'b01);
        drain("tmo_refund", pulses);
        check("tmo_pulses", 13'(pulses), 13'd5);
        step(mk(0, 1, 0, 0, 0, 0, 0), "fault_coin");
        step(mk(0, 0, 1, 0, 0, 0, 0), "fault_sel");
        check("fault_deny", {12'b0, deny}, 13'b1);
        step(mk(0, 0, 0, 0, 1, 0, 0), "fault_cancel");
        drain("fault_refund", pulses);
        do_reset();
        check("fault_cleared", act, 13'b0);

        // Empty slot 2 is refused, slot 0 dispenses and returns 4 pesos.
        step(mk(0, 1, 0, 0, 0, 0, 4), "stock_c5");
        step(mk(1, 0, 0, 0, 0, 0, 4), "stock_c1a");
        step(mk(1, 0, 0, 0, 0, 0, 4), "stock_c1b");
        step(mk(0, 0, 1, 2, 0, 0, 4), "stock_sel2");
        check("stock_deny", {12'b0, deny}, 13'b1);
        step(mk(0, 0, 1, 0, 0, 0, 4), "stock_sel0");
        check("stock_disp", {10'b0, disp_req, disp_slot}, 13'b100);
        step(mk(0, 0, 0, 0, 0, 0, 4), "stock_wait");
        step(mk(0, 0, 0, 0, 0, 1, 4), "stock_ack");
        check("stock_change", {8'b0, credit}, 13'd4);
        drain("stock_refund", pulses);
        check("stock_pulses", 13'(pulses), 13'd4);

        // Reset asserted between edges while a change pulse is high.
        repeat (3) step(mk(1, 0, 0, 0, 0, 0, 0), "rst_coin");
        step(mk(0, 0, 0, 0, 1, 0, 0), "rst_cancel");
        step(idle, "rst_pulse");
        {p1, p5, sel_valid, sel, cancel, stock_empty, disp_ack} = '0;
        reset = 1'b1;
        #2;
        check("async_reset", act, 13'b0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0, 0), "post_reset_coin");
        check("post_reset_credit", {8'b0, credit}, 13'd1);

        rse = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) do_reset();
            if ($urandom_range(49) == 0) rse = 4'($urandom);
            rin = mk($urandom_range(3) == 0 ? 1 : 0, $urandom_range(5) == 0 ? 1 : 0,
                     $urandom_range(4) == 0 ? 1 : 0, int'($urandom_range(3)),
                     $urandom_range(19) == 0 ? 1 : 0, $urandom_range(7) == 0 ? 1 : 0, int'(rse));
            step(rin, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
